opnd_fetch_ctrl: RTL and testbench
==================================

Name: opnd_fetch_ctrl

Overview:
Sequencer that sits between operand decode and execute. It accepts one decoded instruction's operand bundle and issues at most two memory reads over a valid/ready port, operand#0 first and then operand#1. It merges the returned data with the register and immediate operand values and presents one resolved bundle to execute. It owns the memory read port for the operand stage and reports faults and timeouts.

Parameters:
MAX_WAIT, 255, cycles allowed from request acceptance to response before a timeout fault; 0 disables the timeout.
ADDR_W, 32, memory address width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
dec_valid  in  1  decoded operand bundle valid
dec_ready  out  1  controller can accept a bundle
opnd0_is_mem  in  1  operand#0 is a memory operand
opnd1_is_mem  in  1  operand#1 is a memory operand
opnd0_addr  in  ADDR_W  effective address for operand#0
opnd1_addr  in  ADDR_W  effective address for operand#1
opnd0_r  in  32  register/immediate value for operand#0, used when not memory
opnd1_r  in  32  register/immediate value for operand#1, used when not memory
opnd2_r  in  32  operand#2, passed through unchanged
reg_1byte  in  1  byte-sized access
prefix_operand_16bit  in  1  word-sized access when reg_1byte=0
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts the request
mem_req_addr  out  ADDR_W  read address
mem_req_size  out  2  00 byte, 01 word, 10 dword
mem_rsp_valid  in  1  read response valid
mem_rsp_data  in  32  read data
mem_rsp_err  in  1  response carries a bus error
out_valid  out  1  resolved bundle valid
out_ready  in  1  execute consumes the bundle
out_opnd0  out  32  resolved operand#0
out_opnd1  out  32  resolved operand#1
out_opnd2  out  32  operand#2
out_fault  out  1  a memory error or timeout occurred for this bundle

Behaviour:
- Reset (async assert, sync deassert): state IDLE. All outputs 0 except dec_ready=1. Wait counter 0. A reset taken mid-operation discards the in-flight bundle. Any late response after reset is ignored because the state is IDLE.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE: dec_ready=1. On dec_valid&&dec_ready the controller registers all inputs and fixes the size as: reg_1byte gives 00; otherwise prefix_operand_16bit gives 01; otherwise 10.
  - opnd0_is_mem=1 goes to REQ0.
  - Otherwise opnd1_is_mem=1 goes to REQ1.
  - Otherwise goes to DONE.
- dec_ready=0 in every state other than IDLE. There is no overlap of bundles.
- REQ0/REQ1:
  - mem_req_valid=1, with address and size taken from the registered bundle.
  - Address and size hold stable until mem_req_ready is sampled high; the request is accepted on that cycle. The next state is the matching WAIT state and the counter clears.
  - Stalls on mem_req_ready are not timed.
- WAIT0/WAIT1:
  - mem_req_valid=0. The counter increments each cycle that mem_rsp_valid=0.
  - On mem_rsp_valid with err=0, the data is zero-extended by size (byte keeps bits[7:0], word keeps bits[15:0]) and written into the operand slot.
    - From WAIT0: goes to REQ1 if opnd1_is_mem, else DONE.
    - From WAIT1: goes to DONE.
  - On mem_rsp_valid with err=1: the fault flag is set, the slot is written 0, and the state goes to DONE, skipping any remaining request.
  - If MAX_WAIT!=0 and the counter reaches MAX_WAIT with no response: fault is set, the slot is written 0, and the state goes to DONE.
  - Any later stray response is ignored.
- A response arriving in IDLE, REQ or DONE is ignored.
- If mem_rsp_valid arrives on the same cycle the counter hits MAX_WAIT, the response wins.
- Non-memory operand slots take opnd*_r at capture.
- DONE: out_valid=1 and the outputs hold stable until out_ready. On out_valid&&out_ready the fault flag clears and the state goes to IDLE. A new bundle is accepted no earlier than the following cycle.
- Latency from capture to out_valid:
  - No memory operand: 1 cycle.
  - Each memory operand adds at least 2 cycles: 1 for the request plus at least 1 for the response.
- Invariant: at most one outstanding read at any time.

Decomposition:
- Shared defines header carries the state encoding, the MEM_SIZE_BYTE/WORD/DWORD constants, and the size-from-prefix helper function. The helper is reusable by the future write-back controller.
- Sub-module mem_rd_zext (combinational size-based zero-extend) is natural. Everything else stays in one module.

Test Plan:
- Register-only bundle, opnd0_r=0x11, opnd1_r=0x22, opnd2_r=0x33 -> out_valid 1 cycle after capture with 0x11/0x22/0x33, no mem_req_valid, out_fault=0.
- opnd0_is_mem, addr 0x1000, dword, memory returns 0xDEADBEEF after 3 cycles -> exactly one request at 0x1000 with size 10, out_opnd0=0xDEADBEEF.
- Both operands memory, reg_1byte=1, data 0xAABBCC12 then 0x00000034 -> requests at opnd0_addr then opnd1_addr, size 00, out_opnd0=0x12, out_opnd1=0x34.
- mem_req_ready held low for 10 cycles, then a word response 0x12345678 -> mem_req_addr held stable for all 10 cycles, no timeout, out_opnd0=0x5678.
- opnd0 response with err=1 while opnd1_is_mem -> no second request, out_fault=1, out_opnd0=0; after out_ready the next bundle has out_fault=0.
- MAX_WAIT=4 with no response -> out_fault=1 on the 4th wait cycle. A second case, rst_n pulsed in WAIT1, returns the block to IDLE with dec_ready=1 and out_valid=0; a late response is ignored.

Source files
------------

// File: rtl/opnd_fetch_ctrl_pkg.sv
// Shared types for the operand fetch controller:
// state encoding, access sizes and the size helper.
package opnd_fetch_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] MEM_SIZE_BYTE  = 2'b00;
  localparam logic [1:0] MEM_SIZE_WORD  = 2'b01;
  localparam logic [1:0] MEM_SIZE_DWORD = 2'b10;

  typedef struct packed {
    logic [1:0]  size;
    logic        opnd1_is_mem;
    logic [31:0] opnd2;
  } opnd_bndl_t;

  // Byte wins over the 16-bit prefix.
  function automatic logic [1:0] size_from_prefix(
    input logic is_byte,
    input logic is_16
  );
    logic [1:0] sz;
    if (is_byte)
      sz = MEM_SIZE_BYTE;
    else if (is_16)
      sz = MEM_SIZE_WORD;
    else
      sz = MEM_SIZE_DWORD;
    return sz;
  endfunction

endpackage

// File: rtl/opnd_fetch_ctrl_mem_rd_zext.sv
// Size-based zero extension of memory read data.
// Purely combinational.
module mem_rd_zext
  import opnd_fetch_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [31:0] data_zx
);

  always_comb begin
    data_zx = data;
    unique case (size)
      MEM_SIZE_BYTE: data_zx = {24'b0, data[7:0]};
      MEM_SIZE_WORD: data_zx = {16'b0, data[15:0]};
      default:       data_zx = data;
    endcase
  end

endmodule

// File: rtl/opnd_fetch_ctrl.sv
// Operand fetch sequencer: up to two reads, merged
// with register operands into one resolved bundle.
module opnd_fetch_ctrl
  import opnd_fetch_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic              opnd0_is_mem,
  input  logic              opnd1_is_mem,
  input  logic [ADDR_W-1:0] opnd0_addr,
  input  logic [ADDR_W-1:0] opnd1_addr,
  input  logic [31:0]       opnd0_r,
  input  logic [31:0]       opnd1_r,
  input  logic [31:0]       opnd2_r,
  input  logic              reg_1byte,
  input  logic              prefix_operand_16bit,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [1:0]        mem_req_size,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  input  logic              mem_rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_opnd0,
  output logic [31:0]       out_opnd1,
  output logic [31:0]       out_opnd2,
  output logic              out_fault
);

  localparam int CNT_W =
    (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam bit TMO_EN = (MAX_WAIT != 0);
  localparam logic [CNT_W-1:0] CNT_LIM =
    CNT_W'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

  state_t            state_q;
  state_t            state_d;
  opnd_bndl_t        bndl_q;
  logic [ADDR_W-1:0] addr0_q;
  logic [ADDR_W-1:0] addr1_q;
  logic [31:0]       op0_q;
  logic [31:0]       op1_q;
  logic              fault_q;
  logic [CNT_W-1:0]  cnt_q;

  logic        capture;
  logic        in_req;
  logic        in_wait;
  logic        rsp_hit;
  logic        tmo;
  logic        out_hs;
  logic [31:0] rsp_zx;
  logic [31:0] slot_val;

  mem_rd_zext u_zext (
    .size    (bndl_q.size),
    .data    (mem_rsp_data),
    .data_zx (rsp_zx)
  );

  assign capture = (state_q == S_IDLE) && dec_valid;
  assign in_req  = (state_q == S_REQ0) ||
                   (state_q == S_REQ1);
  assign in_wait = (state_q == S_WAIT0) ||
                   (state_q == S_WAIT1);
  assign rsp_hit = in_wait && mem_rsp_valid;
  // A response on the limit cycle beats the timeout.
  assign tmo     = TMO_EN && in_wait &&
                   !mem_rsp_valid &&
                   (cnt_q == CNT_LIM);
  assign out_hs  = out_valid && out_ready;

  assign slot_val =
    (rsp_hit && !mem_rsp_err) ? rsp_zx : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (dec_valid) begin
          if (opnd0_is_mem)
            state_d = S_REQ0;
          else if (opnd1_is_mem)
            state_d = S_REQ1;
          else
            state_d = S_DONE;
        end
      end
      S_REQ0: begin
        if (mem_req_ready)
          state_d = S_WAIT0;
      end
      S_WAIT0: begin
        if (rsp_hit) begin
          if (!mem_rsp_err &&
              bndl_q.opnd1_is_mem)
            state_d = S_REQ1;
          else
            state_d = S_DONE;
        end else if (tmo) begin
          state_d = S_DONE;
        end
      end
      S_REQ1: begin
        if (mem_req_ready)
          state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (rsp_hit || tmo)
          state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dec_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    mem_req_size  = 2'b00;
    out_valid     = 1'b0;
    out_opnd0     = 32'h0;
    out_opnd1     = 32'h0;
    out_opnd2     = 32'h0;
    out_fault     = 1'b0;
    unique case (state_q)
      S_IDLE: dec_ready = 1'b1;
      S_REQ0: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr0_q;
        mem_req_size  = bndl_q.size;
      end
      S_REQ1: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr1_q;
        mem_req_size  = bndl_q.size;
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_opnd0 = op0_q;
        out_opnd1 = op1_q;
        out_opnd2 = bndl_q.opnd2;
        out_fault = fault_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bndl_q  <= '0;
      addr0_q <= '0;
      addr1_q <= '0;
      op0_q   <= 32'h0;
      op1_q   <= 32'h0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (capture) begin
        bndl_q.size <= size_from_prefix(
          reg_1byte, prefix_operand_16bit);
        bndl_q.opnd1_is_mem <= opnd1_is_mem;
        bndl_q.opnd2        <= opnd2_r;
        addr0_q <= opnd0_addr;
        addr1_q <= opnd1_addr;
        op0_q   <= opnd0_r;
        op1_q   <= opnd1_r;
      end
      if (in_req)
        cnt_q <= '0;
      else if (in_wait && !mem_rsp_valid)
        cnt_q <= cnt_q + 1'b1;
      if (rsp_hit || tmo) begin
        if (state_q == S_WAIT0)
          op0_q <= slot_val;
        else
          op1_q <= slot_val;
      end
      if ((rsp_hit && mem_rsp_err) || tmo)
        fault_q <= 1'b1;
      else if (out_hs || capture)
        fault_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_opnd_fetch_ctrl.sv
// Bench for opnd_fetch_ctrl: vector table driven
// through a memory model with request/result queues.
module tb_opnd_fetch_ctrl;

  localparam int TO = 99;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid = 1'b0;
  logic        dec_ready;
  logic        opnd0_is_mem = 1'b0;
  logic        opnd1_is_mem = 1'b0;
  logic [31:0] opnd0_addr = '0;
  logic [31:0] opnd1_addr = '0;
  logic [31:0] opnd0_r = '0;
  logic [31:0] opnd1_r = '0;
  logic [31:0] opnd2_r = '0;
  logic        reg_1byte = 1'b0;
  logic        prefix_operand_16bit = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic [1:0]  mem_req_size;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        mem_rsp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_opnd0;
  logic [31:0] out_opnd1;
  logic [31:0] out_opnd2;
  logic        out_fault;

  opnd_fetch_ctrl #(
    .MAX_WAIT (MW),
    .ADDR_W   (32)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .dec_valid            (dec_valid),
    .dec_ready            (dec_ready),
    .opnd0_is_mem         (opnd0_is_mem),
    .opnd1_is_mem         (opnd1_is_mem),
    .opnd0_addr           (opnd0_addr),
    .opnd1_addr           (opnd1_addr),
    .opnd0_r              (opnd0_r),
    .opnd1_r              (opnd1_r),
    .opnd2_r              (opnd2_r),
    .reg_1byte            (reg_1byte),
    .prefix_operand_16bit (prefix_operand_16bit),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req_addr         (mem_req_addr),
    .mem_req_size         (mem_req_size),
    .mem_rsp_valid        (mem_rsp_valid),
    .mem_rsp_data         (mem_rsp_data),
    .mem_rsp_err          (mem_rsp_err),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .out_opnd0            (out_opnd0),
    .out_opnd1            (out_opnd1),
    .out_opnd2            (out_opnd2),
    .out_fault            (out_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          m0, m1, b1, w16;
    logic [31:0] a0, a1, r0, r1, r2, d0, d1;
    bit          e0;
    int          stall, lat0, lat1, hold;
    logic [31:0] x0, x1;
    bit          xf;
  } vec_t;

  typedef struct {
    logic [31:0] o0, o1, o2;
    logic        f;
  } out_t;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
  } req_t;

  out_t exp_q[$];
  req_t req_q[$];
  vec_t vt[10];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h",
               nm, act, exp);
    end
  endtask

  function automatic int wcyc(input int l);
    return (l == TO) ? MW : l + 1;
  endfunction

  function automatic bit fail0(input vec_t v);
    return v.e0 || (v.lat0 == TO);
  endfunction

  function automatic int exp_lat(input vec_t v);
    int l;
    l = 1;
    if (v.m0)
      l += 1 + v.stall + wcyc(v.lat0);
    if (v.m1 && !(v.m0 && fail0(v)))
      l += 1 + (v.m0 ? 0 : v.stall) +
           wcyc(v.lat1);
    return l;
  endfunction

  task automatic run_vec(input int id,
                         input vec_t v);
    int cyc, stall_left, wait_left, nreq;
    int hold;
    bit in_wait, done, seen, slot1;
    logic [1:0] sz;
    logic [31:0] d;
    logic er;
    out_t e;
    req_t r;
    chk($sformatf("v%0d_dec_ready", id),
        dec_ready, 1);
    sz = v.b1 ? 2'b00 : (v.w16 ? 2'b01 : 2'b10);
    dec_valid = 1'b1;
    opnd0_is_mem = v.m0;
    opnd1_is_mem = v.m1;
    opnd0_addr = v.a0;
    opnd1_addr = v.a1;
    opnd0_r = v.r0;
    opnd1_r = v.r1;
    opnd2_r = v.r2;
    reg_1byte = v.b1;
    prefix_operand_16bit = v.w16;
    if (v.m0)
      req_q.push_back('{v.a0, sz});
    if (v.m1 && !(v.m0 && fail0(v)))
      req_q.push_back('{v.a1, sz});
    exp_q.push_back('{v.x0, v.x1, v.r2, v.xf});
    @(posedge clk);
    @(negedge clk);
    dec_valid = 1'b0;
    cyc = 1;
    stall_left = v.stall;
    wait_left = 0;
    nreq = 0;
    hold = v.hold;
    in_wait = 0;
    done = 0;
    seen = 0;
    d = '0;
    er = 1'b0;
    while (!done && cyc < 100) begin
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data = '0;
      mem_rsp_err = 1'b0;
      out_ready = 1'b0;
      if (mem_req_valid) begin
        if (req_q.size() == 0) begin
          chk($sformatf("v%0d_extra_req", id),
              mem_req_valid, 0);
        end else if (stall_left > 0) begin
          chk($sformatf("v%0d_addr_hold", id),
              mem_req_addr, req_q[0].addr);
          stall_left--;
        end else begin
          r = req_q.pop_front();
          chk($sformatf("v%0d_req_addr", id),
              mem_req_addr, r.addr);
          chk($sformatf("v%0d_req_size", id),
              {30'b0, mem_req_size},
              {30'b0, r.size});
          mem_req_ready = 1'b1;
          slot1 = !(v.m0 && nreq == 0);
          wait_left = slot1 ? v.lat1 : v.lat0;
          d  = slot1 ? v.d1 : v.d0;
          er = slot1 ? 1'b0 : v.e0;
          in_wait = 1;
          nreq++;
        end
      end else if (out_valid) begin
        in_wait = 0;
        if (!seen)
          chk($sformatf("v%0d_latency", id),
              cyc, exp_lat(v));
        seen = 1;
        e = exp_q[0];
        chk($sformatf("v%0d_opnd0", id),
            out_opnd0, e.o0);
        chk($sformatf("v%0d_opnd1", id),
            out_opnd1, e.o1);
        chk($sformatf("v%0d_opnd2", id),
            out_opnd2, e.o2);
        chk($sformatf("v%0d_fault", id),
            out_fault, e.f);
        if (hold > 0) begin
          hold--;
        end else begin
          out_ready = 1'b1;
          void'(exp_q.pop_front());
          done = 1;
        end
      end else if (in_wait) begin
        chk($sformatf("v%0d_busy", id),
            dec_ready, 0);
        if (wait_left == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data = d;
          mem_rsp_err = er;
          in_wait = 0;
        end else if (wait_left != TO) begin
          wait_left--;
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    out_ready = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL v%0d_no_output: %0d cycles",
               id, cyc);
      exp_q.delete();
    end
    chk($sformatf("v%0d_req_left", id),
        req_q.size(), 0);
    req_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{0,0,0,0, 'h0,'h0,
              'h11,'h22,'h33, 'h0,'h0,
              0, 0,0,0,0, 'h11,'h22, 0};
    vt[1] = '{1,0,0,0, 'h1000,'h0,
              'hFFFF0000,'h55,'h66,
              'hDEADBEEF,'h0,
              0, 0,3,0,1, 'hDEADBEEF,'h55, 0};
    vt[2] = '{1,1,1,0, 'h2000,'h2004,
              'h99,'h98,'h97,
              'hAABBCC12,'h34,
              0, 0,1,2,2, 'h12,'h34, 0};
    vt[3] = '{1,0,0,1, 'h3000,'h0,
              'h0,'h0,'h1234,
              'h12345678,'h0,
              0, 10,0,0,0, 'h5678,'h0, 0};
    vt[4] = '{1,1,0,0, 'h4000,'h4004,
              'h0,'h77,'h88,
              'hCAFEF00D,'h0,
              1, 0,1,0,0, 'h0,'h77, 1};
    vt[5] = '{0,0,0,0, 'h0,'h0,
              'hA5,'h5A,'hC3, 'h0,'h0,
              0, 0,0,0,0, 'hA5,'h5A, 0};
    vt[6] = '{0,1,0,0, 'h5000,'h6000,
              'h0BADF00D,'h0,'h1,
              'h0,'h89ABCDEF,
              0, 0,0,2,0,
              'h0BADF00D,'h89ABCDEF, 0};
    vt[7] = '{1,1,0,0, 'h7000,'h7004,
              'h0,'h44,'h45, 'h0,'h0,
              0, 0,TO,0,0, 'h0,'h44, 1};
    vt[8] = '{0,1,0,1, 'h0,'h8000,
              'h31,'h32,'h33, 'h0,'h0,
              0, 0,0,TO,0, 'h31,'h0, 1};
    vt[9] = '{1,1,0,1, 'h9000,'h9002,
              'h0,'h0,'h0,
              'hFFFF8001,'h0001FFFF,
              0, 0,3,3,0, 'h8001,'hFFFF, 0};

    @(negedge clk);
    chk("rst_dec_ready", dec_ready, 1);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_fault", out_fault, 0);
    chk("rst_out_opnd0", out_opnd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_vec(i, vt[i]);

    dec_valid = 1'b1;
    opnd0_is_mem = 1'b1;
    opnd1_is_mem = 1'b1;
    opnd0_addr = 'hA000;
    opnd1_addr = 'hA004;
    reg_1byte = 1'b0;
    prefix_operand_16bit = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dec_valid = 1'b0;
    chk("mr_req0", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 'h1111;
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("mr_req1", mem_req_valid, 1);
    chk("mr_req1_addr", mem_req_addr, 'hA004);
    mem_req_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("mr_wait1_busy", dec_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_rst_dec_ready", dec_ready, 1);
    chk("mr_rst_out_valid", out_valid, 0);
    chk("mr_rst_req_valid", mem_req_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data = 'h2222;
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    chk("late_out_valid", out_valid, 0);
    chk("late_dec_ready", dec_ready, 1);
    chk("late_req_valid", mem_req_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("late_out_valid2", out_valid, 0);
    run_vec(10, vt[0]);

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
